// File: rtl/conv_pkg.sv
// Shared types, default widths and the result saturation helper for the systolic convolution array.
package conv_pkg;

   localparam int unsigned DEF_DATA_W = 16;
   localparam int unsigned DEF_ACC_W  = 40;
   localparam int unsigned DEF_OUT_W  = 32;
   localparam int unsigned DEF_TAP_W  = 8;
   localparam int unsigned SAT_W      = 64;

   typedef enum logic {
      IDLE  = 1'b0,
      ACCUM = 1'b1
   } pe_state_e;

   // Clamp a sign-extended value to the signed range of an out_w-bit result.
   function automatic logic signed [SAT_W-1:0] sat_to_out(input logic signed [SAT_W-1:0] val,
                                                          input int unsigned out_w);
      logic signed [SAT_W-1:0] hi;
      logic signed [SAT_W-1:0] lo;
      hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
      lo = -hi - 64'sd1;
      if (val > hi)      return hi;
      else if (val < lo) return lo;
      else               return val;
   endfunction

endpackage

// File: rtl/conv_systolic_pe_if.sv
// Result handshake between a processing element and the row collector.
interface conv_systolic_pe_if #(
   parameter int unsigned OUT_W = 32
);
   logic signed [OUT_W-1:0] res_out;
   logic                    res_vld;
   logic                    res_rdy;

   modport master (output res_out, res_vld, input res_rdy);
   modport slave  (input res_out, res_vld, output res_rdy);
endinterface

// File: rtl/conv_res_fifo.sv
// Two-entry synchronous result FIFO; push and pop in the same cycle are legal at any occupancy.
module conv_res_fifo #(
   parameter int unsigned OUT_W = 32
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    push,
   input  logic signed [OUT_W-1:0] wr_data,
   input  logic                    pop,
   output logic signed [OUT_W-1:0] rd_data,
   output logic                    full,
   output logic                    empty
);

   logic signed [OUT_W-1:0] mem [2];
   logic                    rd_ptr;
   logic                    wr_ptr;
   logic [1:0]              count;
   logic                    do_push;
   logic                    do_pop;

   // A pop frees the head slot, so a full FIFO may accept a push in the same cycle.
   assign do_pop  = pop & (count != 2'd0);
   assign do_push = push & ((count != 2'd2) | do_pop);

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 2; i++) mem[i] <= '0;
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= wr_data;
            wr_ptr      <= ~wr_ptr;
         end
         if (do_pop) rd_ptr <= ~rd_ptr;
         count <= count + 2'(do_push) - 2'(do_pop);
      end
   end

   assign rd_data = mem[rd_ptr];
   assign full    = (count == 2'd2);
   assign empty   = (count == 2'd0);

endmodule

// File: rtl/conv_systolic_pe.sv
// Systolic convolution PE: forwards operands east/south, accumulates a tap window, buffers saturated results.
// Define CONV_PE_RELU_EN to clamp negative results to zero before they enter the buffer.
module conv_systolic_pe
   import conv_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned ACC_W  = DEF_ACC_W,
   parameter int unsigned OUT_W  = DEF_OUT_W,
   parameter int unsigned TAP_W  = DEF_TAP_W
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     en,
   input  logic [TAP_W-1:0]         taps_cfg,
   input  logic signed [DATA_W-1:0] a_in,
   input  logic                     a_vld_in,
   input  logic signed [DATA_W-1:0] b_in,
   input  logic                     b_vld_in,
   output logic signed [DATA_W-1:0] a_out,
   output logic                     a_vld_out,
   output logic signed [DATA_W-1:0] b_out,
   output logic                     b_vld_out,
   conv_systolic_pe_if.master       res_if,
   output logic                     busy,
   output logic                     res_ovf
);

   localparam int unsigned PROD_W = 2 * DATA_W;

   pe_state_e               state;
   pe_state_e               state_d;
   logic signed [ACC_W-1:0] acc;
   logic signed [ACC_W-1:0] acc_d;
   logic [TAP_W-1:0]        tap_cnt;
   logic [TAP_W-1:0]        tap_cnt_d;
   logic [TAP_W-1:0]        win_q;
   logic [TAP_W-1:0]        win_d;
   logic [TAP_W-1:0]        win;
   logic                    fire;
   logic                    done;
   logic signed [PROD_W-1:0] prod;
   logic signed [ACC_W-1:0] prod_ext;
   logic signed [ACC_W-1:0] acc_sum;
   logic signed [ACC_W-1:0] res_acc;
   logic signed [SAT_W-1:0] res_sat;
   logic signed [OUT_W-1:0] res_val;
   logic signed [OUT_W-1:0] fifo_rd_data;
   logic                    fifo_full;
   logic                    fifo_empty;

   assign fire     = en & a_vld_in & b_vld_in;
   assign prod     = a_in * b_in;
   assign prod_ext = ACC_W'(prod);
   assign acc_sum  = acc + prod_ext;
   assign win      = (taps_cfg == '0) ? TAP_W'(1) : taps_cfg;

   // Operand forwarding, frozen while en is low.
   always_ff @(posedge clk) begin
      if (reset) begin
         a_out     <= '0;
         a_vld_out <= 1'b0;
         b_out     <= '0;
         b_vld_out <= 1'b0;
      end else if (en) begin
         a_out     <= a_in;
         a_vld_out <= a_vld_in;
         b_out     <= b_in;
         b_vld_out <= b_vld_in;
      end
   end

   // State and MAC registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         acc     <= '0;
         tap_cnt <= '0;
         win_q   <= '0;
      end else begin
         state   <= state_d;
         acc     <= acc_d;
         tap_cnt <= tap_cnt_d;
         win_q   <= win_d;
      end
   end

   always_comb begin
      state_d = state;
      case (state)
         IDLE:    if (fire && win != TAP_W'(1)) state_d = ACCUM;
         ACCUM:   if (fire && tap_cnt == win_q - TAP_W'(1)) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath updates; a completing fire clears the accumulator and raises done.
   always_comb begin
      acc_d     = acc;
      tap_cnt_d = tap_cnt;
      win_d     = win_q;
      done      = 1'b0;
      res_acc   = acc_sum;
      case (state)
         IDLE: begin
            if (fire) begin
               win_d = win;
               if (win == TAP_W'(1)) begin
                  done      = 1'b1;
                  res_acc   = prod_ext;
                  acc_d     = '0;
                  tap_cnt_d = '0;
               end else begin
                  acc_d     = prod_ext;
                  tap_cnt_d = TAP_W'(1);
               end
            end
         end
         ACCUM: begin
            if (fire) begin
               if (tap_cnt == win_q - TAP_W'(1)) begin
                  done      = 1'b1;
                  acc_d     = '0;
                  tap_cnt_d = '0;
               end else begin
                  acc_d     = acc_sum;
                  tap_cnt_d = tap_cnt + TAP_W'(1);
               end
            end
         end
         default: ;
      endcase
   end

   assign res_sat = sat_to_out(SAT_W'(res_acc), OUT_W);

`ifdef CONV_PE_RELU_EN
   assign res_val = res_sat[OUT_W-1] ? '0 : OUT_W'(res_sat);
`else
   assign res_val = OUT_W'(res_sat);
`endif

   conv_res_fifo #(.OUT_W(OUT_W)) u_res_fifo (
      .clk     (clk),
      .reset   (reset),
      .push    (done),
      .wr_data (res_val),
      .pop     (res_if.res_rdy),
      .rd_data (fifo_rd_data),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   // Sticky drop flag: a completed window found the buffer full with no pop.
   always_ff @(posedge clk) begin
      if (reset)                                   res_ovf <= 1'b0;
      else if (done && fifo_full && !res_if.res_rdy) res_ovf <= 1'b1;
   end

   assign res_if.res_out = fifo_rd_data;
   assign res_if.res_vld = ~fifo_empty;
   assign busy           = (state == ACCUM);

endmodule
